riscv_csr_dbg_master: RTL and testbench

RISCV_CSR_DBG_MASTER -- requirements
Module: riscv_csr_dbg_master

---
 rtl/riscv_csr_dbg_master.sv | 120 ++++++++++++
 tb/tb_riscv_csr_dbg_master.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_csr_dbg_master.sv
// Debug-side CSR access master: arbitrates debug CSR requests against the core pipeline
// on a shared CSR register-file port, with a starvation limit that briefly stalls the core.
module riscv_csr_dbg_master #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dbg_req_i,
  output logic        dbg_gnt_o,
  input  logic [11:0] dbg_addr_i,
  input  logic [1:0]  dbg_op_i,
  input  logic [31:0] dbg_wdata_i,
  output logic        dbg_rvalid_o,
  input  logic        dbg_rready_i,
  output logic [31:0] dbg_rdata_o,
  output logic        dbg_err_o,
  input  logic        core_csr_access_i,
  input  logic [11:0] core_csr_addr_i,
  input  logic [31:0] core_csr_wdata_i,
  input  logic [1:0]  core_csr_op_i,
  output logic [31:0] core_csr_rdata_o,
  output logic        core_stall_o,
  output logic        csr_access_o,
  output logic [11:0] csr_addr_o,
  output logic [31:0] csr_wdata_o,
  output logic [1:0]  csr_op_o,
  input  logic [31:0] csr_rdata_i
);

  localparam logic [1:0] CSR_OP_NONE = 2'b00;
  localparam logic [7:0] LIMIT       = 8'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_reg;
  logic [11:0] addr_reg;
  logic [1:0]  op_reg;
  logic [31:0] wdata_reg;
  logic [7:0]  starve_cnt_reg;
  logic        rvalid_reg;
  logic        err_reg;
  logic [31:0] rdata_reg;

  logic reject;
  logic at_limit;
  logic slot_free;
  logic dbg_issue;

  // The top quarter of CSR space is read-only; any modifying op there is refused.
  assign reject    = (dbg_addr_i[11:10] == 2'b11) && (dbg_op_i != CSR_OP_NONE);
  assign at_limit  = (starve_cnt_reg == LIMIT);
  assign slot_free = !core_csr_access_i || at_limit;
  assign dbg_issue = (state_reg == WAIT) && slot_free;

  assign dbg_gnt_o    = (state_reg == IDLE) && dbg_req_i;
  assign core_stall_o = (state_reg == WAIT) && core_csr_access_i && at_limit;

  assign csr_access_o = dbg_issue ? 1'b1      : core_csr_access_i;
  assign csr_addr_o   = dbg_issue ? addr_reg  : core_csr_addr_i;
  assign csr_wdata_o  = dbg_issue ? wdata_reg : core_csr_wdata_i;
  assign csr_op_o     = dbg_issue ? op_reg    : core_csr_op_i;

  assign core_csr_rdata_o = csr_rdata_i;
  assign dbg_rvalid_o     = rvalid_reg;
  assign dbg_rdata_o      = rdata_reg;
  assign dbg_err_o        = err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      op_reg         <= CSR_OP_NONE;
      wdata_reg      <= '0;
      starve_cnt_reg <= '0;
      rvalid_reg     <= 1'b0;
      err_reg        <= 1'b0;
      rdata_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          starve_cnt_reg <= '0;
          if (dbg_req_i) begin
            addr_reg  <= dbg_addr_i;
            op_reg    <= dbg_op_i;
            wdata_reg <= dbg_wdata_i;
            if (reject) begin
              state_reg  <= RESP;
              rvalid_reg <= 1'b1;
              err_reg    <= 1'b1;
              rdata_reg  <= '0;
            end else begin
              state_reg <= WAIT;
            end
          end
        end
        WAIT: begin
          if (slot_free) begin
            // Old CSR value is captured in the same cycle the bus carries the access.
            rdata_reg      <= csr_rdata_i;
            err_reg        <= 1'b0;
            rvalid_reg     <= 1'b1;
            starve_cnt_reg <= '0;
            state_reg      <= RESP;
          end else if (!at_limit) begin
            starve_cnt_reg <= starve_cnt_reg + 8'd1;
          end
        end
        RESP: begin
          starve_cnt_reg <= '0;
          if (dbg_rready_i) begin
            rvalid_reg <= 1'b0;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_csr_dbg_master.sv
// Randomized scoreboard bench for riscv_csr_dbg_master: a CSR-file environment, a value-level
// reference model, and a monitor that checks bus issues and debug responses against queues.
module tb_riscv_csr_dbg_master;

  localparam int STARVE = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dbg_req_i = 1'b0;
  logic        dbg_gnt_o;
  logic [11:0] dbg_addr_i = '0;
  logic [1:0]  dbg_op_i = '0;
  logic [31:0] dbg_wdata_i = '0;
  logic        dbg_rvalid_o;
  logic        dbg_rready_i = 1'b1;
  logic [31:0] dbg_rdata_o;
  logic        dbg_err_o;
  logic        core_csr_access_i = 1'b0;
  logic [11:0] core_csr_addr_i = '0;
  logic [31:0] core_csr_wdata_i = '0;
  logic [1:0]  core_csr_op_i = '0;
  logic [31:0] core_csr_rdata_o;
  logic        core_stall_o;
  logic        csr_access_o;
  logic [11:0] csr_addr_o;
  logic [31:0] csr_wdata_o;
  logic [1:0]  csr_op_o;
  logic [31:0] csr_rdata_i;

  riscv_csr_dbg_master #(.STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .rst_n(rst_n),
    .dbg_req_i(dbg_req_i), .dbg_gnt_o(dbg_gnt_o), .dbg_addr_i(dbg_addr_i),
    .dbg_op_i(dbg_op_i), .dbg_wdata_i(dbg_wdata_i), .dbg_rvalid_o(dbg_rvalid_o),
    .dbg_rready_i(dbg_rready_i), .dbg_rdata_o(dbg_rdata_o), .dbg_err_o(dbg_err_o),
    .core_csr_access_i(core_csr_access_i), .core_csr_addr_i(core_csr_addr_i),
    .core_csr_wdata_i(core_csr_wdata_i), .core_csr_op_i(core_csr_op_i),
    .core_csr_rdata_o(core_csr_rdata_o), .core_stall_o(core_stall_o),
    .csr_access_o(csr_access_o), .csr_addr_o(csr_addr_o), .csr_wdata_o(csr_wdata_o),
    .csr_op_o(csr_op_o), .csr_rdata_i(csr_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [11:0] a; logic [1:0] op; logic [31:0] wd;} iss_t;
  typedef struct packed {logic e; logic [31:0] rd;} rsp_t;

  iss_t issue_q[$];
  rsp_t resp_q[$];

  int checks = 0, errors = 0;
  int cyc = 0;
  int core_mode = 0;    // 0 idle, 1 random, 2 always accessing
  int rready_mode = 1;  // 0 hold low, 1 always high, 2 random
  int gnt_cyc = 0, last_issue_cyc = 0, last_rvalid_cyc = 0;
  int issues = 0, stall_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [11:0] a);
    if (a == 12'h341) return 32'h0000_1000;
    return {20'hC5A30, a};
  endfunction

  // CSR register file environment: combinational read, write on access edge.
  logic [31:0] csr_mem [0:4095];
  initial for (int i = 0; i < 4096; i++) csr_mem[i] = init_val(12'(i));
  assign csr_rdata_i = csr_mem[csr_addr_o];
  always @(posedge clk) begin
    if (csr_access_o) begin
      case (csr_op_o)
        2'b01: csr_mem[csr_addr_o] <= csr_wdata_o;
        2'b10: csr_mem[csr_addr_o] <= csr_mem[csr_addr_o] | csr_wdata_o;
        2'b11: csr_mem[csr_addr_o] <= csr_mem[csr_addr_o] & ~csr_wdata_o;
        default: ;
      endcase
    end
  end

  // Reference model: architectural CSR values and the access-rejection rule.
  logic [31:0] ref_csr [logic [11:0]];
  task automatic predict(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                         output logic [31:0] rd, output logic e);
    logic [31:0] cur;
    cur = ref_csr.exists(a) ? ref_csr[a] : init_val(a);
    if (a[11:10] == 2'b11 && op != 2'b00) begin
      rd = '0;
      e  = 1'b1;
    end else begin
      rd = cur;
      e  = 1'b0;
      if (op == 2'b01) ref_csr[a] = wd;
      else if (op == 2'b10) ref_csr[a] = cur | wd;
      else if (op == 2'b11) ref_csr[a] = cur & ~wd;
    end
  endtask

  // Core traffic (reads only) and response backpressure.
  always @(posedge clk) begin
    #1;
    case (core_mode)
      1: core_csr_access_i = ($urandom % 2) == 0;
      2: core_csr_access_i = 1'b1;
      default: core_csr_access_i = 1'b0;
    endcase
    core_csr_addr_i  = 12'($urandom);
    core_csr_wdata_i = $urandom;
    core_csr_op_i    = 2'b00;
    case (rready_mode)
      0: dbg_rready_i = 1'b0;
      2: dbg_rready_i = ($urandom % 3) != 0;
      default: dbg_rready_i = 1'b1;
    endcase
  end

  // Monitor
  logic hold_prev = 1'b0, rv_prev = 1'b0, dbg_iss;
  logic [32:0] held;
  iss_t it;
  rsp_t rt;
  always @(negedge clk) begin
    dbg_iss = csr_access_o && (!core_csr_access_i || core_stall_o);
    chk("core_rdata_passthru", 64'(core_csr_rdata_o), 64'(csr_rdata_i));
    if (!rst_n) begin
      chk("reset_mirror", 64'({csr_access_o, csr_addr_o, csr_wdata_o, csr_op_o}),
          64'({core_csr_access_i, core_csr_addr_i, core_csr_wdata_i, core_csr_op_i}));
      chk("reset_outputs", 64'({dbg_rvalid_o, dbg_err_o, dbg_rdata_o, core_stall_o}), 64'(0));
      hold_prev = 1'b0;
      rv_prev   = 1'b0;
    end else begin
      if (dbg_iss) begin
        issues++;
        last_issue_cyc = cyc;
        if (core_stall_o) stall_total++;
        checks++;
        if (issue_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_issue: got debug access addr %h op %0d, expected none", csr_addr_o, csr_op_o);
        end else begin
          it = issue_q.pop_front();
          checks--;
          chk("issue_fields", 64'({csr_addr_o, csr_op_o, csr_wdata_o}), 64'(it));
        end
      end else begin
        chk("mirror", 64'({csr_access_o, csr_addr_o, csr_wdata_o, csr_op_o}),
            64'({core_csr_access_i, core_csr_addr_i, core_csr_wdata_i, core_csr_op_i}));
      end
      chk("gnt_rule", 64'(dbg_gnt_o && (dbg_rvalid_o || !dbg_req_i)), 64'(0));
      if (dbg_rvalid_o && !rv_prev) last_rvalid_cyc = cyc;
      if (hold_prev) begin
        chk("hold_valid", 64'(dbg_rvalid_o), 64'(1));
        chk("hold_data", 64'({dbg_err_o, dbg_rdata_o}), 64'(held));
      end
      if (dbg_rvalid_o && dbg_rready_i) begin
        checks++;
        if (resp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp: got rdata %h err %0d, expected no response", dbg_rdata_o, dbg_err_o);
        end else begin
          rt = resp_q.pop_front();
          checks--;
          chk("resp", 64'({dbg_err_o, dbg_rdata_o}), 64'(rt));
          $display("resp: rdata=%h err=%0d (expected %h/%0d) cycle %0d", dbg_rdata_o, dbg_err_o, rt.rd, rt.e, cyc);
        end
      end
      hold_prev = dbg_rvalid_o && !dbg_rready_i;
      held      = {dbg_err_o, dbg_rdata_o};
      rv_prev   = dbg_rvalid_o;
    end
  end

  task automatic do_req(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd, input bit keep);
    bit got;
    logic [31:0] rd;
    logic e;
    @(posedge clk); #1;
    dbg_req_i = 1'b1; dbg_addr_i = a; dbg_op_i = op; dbg_wdata_i = wd;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (dbg_gnt_o) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL grant_timeout: got no grant for addr %h, expected grant", a);
      dbg_req_i = 1'b0;
    end else begin
      gnt_cyc = cyc;
      predict(a, op, wd, rd, e);
      resp_q.push_back({e, rd});
      if (!e) issue_q.push_back({a, op, wd});
      $display("req: addr=%h op=%0d wdata=%h granted cycle %0d", a, op, wd, cyc);
      if (!keep) begin
        @(posedge clk); #1;
        dbg_req_i = 1'b0;
      end
    end
  endtask

  task automatic wait_done();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      #1;
      done = (resp_q.size() == 0) && (issue_q.size() == 0);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL completion_timeout: got %0d responses pending, expected 0", resp_q.size());
    end
  endtask

  logic [11:0] addr_tab [8] = '{12'h300, 12'h341, 12'h700, 12'h7B0, 12'h343, 12'hC00, 12'hF14, 12'hB00};
  int i0, s0, rv_wait;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic read latency, core idle
    do_req(12'h341, 2'b00, 32'h0, 1'b0);
    wait_done();
    chk("lat_issue", 64'(last_issue_cyc - gnt_cyc), 64'(1));
    chk("lat_rvalid", 64'(last_rvalid_cyc - gnt_cyc), 64'(2));

    // Write then read back
    i0 = issues;
    do_req(12'h700, 2'b01, 32'hA5A5_A5A5, 1'b0);
    wait_done();
    do_req(12'h700, 2'b00, 32'h0, 1'b0);
    wait_done();
    chk("write_read_issues", 64'(issues - i0), 64'(2));

    // Starvation: core accesses every cycle
    core_mode = 2;
    s0 = stall_total;
    do_req(12'h300, 2'b00, 32'h0, 1'b0);
    wait_done();
    chk("starve_wait", 64'(last_issue_cyc - gnt_cyc), 64'(STARVE + 1));
    chk("starve_stalls", 64'(stall_total - s0), 64'(1));
    core_mode = 0;

    // Rejected write into read-only space
    i0 = issues;
    do_req(12'hF10, 2'b01, 32'hDEAD_BEEF, 1'b0);
    wait_done();
    chk("reject_no_issue", 64'(issues - i0), 64'(0));
    chk("reject_lat", 64'(last_rvalid_cyc - gnt_cyc), 64'(1));

    // Backpressure with a new request held throughout RESP
    rready_mode = 0;
    do_req(12'h341, 2'b00, 32'h0, 1'b1);
    rv_wait = 0;
    while (!dbg_rvalid_o && rv_wait < 50) begin @(negedge clk); rv_wait++; end
    chk("bp_rvalid_seen", 64'(dbg_rvalid_o), 64'(1));
    repeat (5) @(negedge clk);
    rready_mode = 1;
    do_req(12'h700, 2'b00, 32'h0, 1'b0);
    wait_done();

    // Reset while waiting for a slot
    core_mode = 2;
    i0 = issues;
    do_req(12'h343, 2'b00, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    resp_q.delete();
    issue_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    core_mode = 0;
    repeat (4) @(negedge clk);
    chk("reset_drop_no_issue", 64'(issues - i0), 64'(0));
    do_req(12'h341, 2'b00, 32'h0, 1'b0);
    wait_done();

    // Randomized traffic
    core_mode = 1;
    rready_mode = 2;
    for (int n = 0; n < 150; n++) begin
      do_req(addr_tab[$urandom % 8], 2'($urandom), $urandom, (n != 149) && (($urandom % 4) == 0));
    end
    wait_done();
    core_mode = 0;
    rready_mode = 1;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
